// File: rtl/output_port_allocator.sv
// output_port_allocator: per-output-port round-robin switch allocator with packet lock and credit gating
module output_port_allocator #(
  parameter int NUM_IN = 5,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] req_head,
  input  logic [NUM_IN-1:0] req_tail,
  input  logic              credit_avail,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              out_unit_en,
  output logic              credit_decre,
  output logic              locked,
  output logic              proto_err
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt, owner, owner_nxt, win;
  logic             win_vld, proto_nxt;
  logic [NUM_IN-1:0] elig;
  assign elig = req & req_head;
  always_comb begin
    win = '0;
    win_vld = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr) + k) % NUM_IN]) begin
        win_vld = 1'b1;
        win = IDX_W'((int'(rr_ptr) + k) % NUM_IN);
      end
    end
  end
  always_comb begin
    state_nxt = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt = owner;
    proto_nxt = proto_err;
    grant = '0;
    grant_idx = '0;
    if (state == IDLE) begin
      if (|(req & ~req_head)) proto_nxt = 1'b1;
      if (win_vld && credit_avail) begin
        grant = NUM_IN'(1) << win;
        grant_idx = win;
        rr_ptr_nxt = (win == IDX_W'(NUM_IN - 1)) ? '0 : win + IDX_W'(1);
        if (!req_tail[win]) begin
          owner_nxt = win;
          state_nxt = LOCKED;
        end
      end
    end else begin
      if (req[owner] && req_head[owner]) proto_nxt = 1'b1;
      if (req[owner] && credit_avail) begin
        grant = NUM_IN'(1) << owner;
        grant_idx = owner;
        if (req_tail[owner]) state_nxt = IDLE;
      end
    end
    if (rst) begin
      grant = '0;
      grant_idx = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      owner <= owner_nxt;
      proto_err <= proto_nxt;
    end
  end
  assign out_unit_en = |grant;
  assign credit_decre = |grant;
  assign locked = (state == LOCKED);
endmodule
